risc_control_fsm: RTL and testbench

- Multicycle control unit for the RISC core.
- Sequences fetch, decode, execute, memory and writeback around the instruction register, the instruction decoder, the register file, the ALU and the PC incrementor.
- Consumes the 7-bit decoded operation field and the ALU zero flag.
- Drives every datapath enable, plus a req/ready handshake to the shared instruction/data memory port.

---
 rtl/risc_control_fsm_if.sv | 21 ++
 rtl/risc_control_fsm.sv | 155 +++++++++++++++
 tb/tb_risc_control_fsm.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_control_fsm_if.sv
// Shared instruction/data memory port: request, write strobe and address select out, ready back.
interface risc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/risc_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-wait timeout.
// Outputs are combinational from state (plus mem_ready/alu_zero) and forced low while rst_n is low.
module risc_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  risc_control_fsm_if.master   mem,
  input  logic [6:0]           operation,
  input  logic                 alu_zero,
  output logic                 ir_load,
  output logic                 dec_en,
  output logic                 alu_en,
  output logic [1:0]           alu_src_imm,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 pc_src_l,
  output logic                 reg_write,
  output logic                 wb_sel_mem,
  output logic                 halted,
  output logic                 err,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_ERROR   = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [2:0] C_ALU   = 3'd0;
  localparam logic [2:0] C_IMM   = 3'd1;
  localparam logic [2:0] C_SHIFT = 3'd2;
  localparam logic [2:0] C_LOAD  = 3'd3;
  localparam logic [2:0] C_STORE = 3'd4;
  localparam logic [2:0] C_BEQZ  = 3'd5;
  localparam logic [2:0] C_JUMP  = 3'd6;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic [2:0]          op_class;
  logic                is_halt;
  logic                mem_wait;
  logic                timeout_hit;

  assign op_class = operation[6:4];
  assign is_halt  = (operation[6:4] == 3'd7) && (operation[3:0] == 4'hF);
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready;
  // Counter sits at MEM_TIMEOUT-2 during the last tolerated cycle; a miss there would make it MEM_TIMEOUT-1.
  assign timeout_hit = mem_wait && (wait_q == WAIT_W'(MEM_TIMEOUT - 2));
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (mem_wait) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_load          = 1'b0;
    dec_en           = 1'b0;
    alu_en           = 1'b0;
    alu_src_imm      = 2'b00;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    pc_src_l         = 1'b0;
    reg_write        = 1'b0;
    wb_sel_mem       = 1'b0;
    halted           = 1'b0;
    err              = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_ERROR;
          end
        end
        S_DECODE: begin
          dec_en  = 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          alu_en = 1'b1;
          case (op_class)
            C_ALU:   state_d = S_WB;
            C_IMM: begin
              alu_src_imm = 2'b01;
              state_d     = S_WB;
            end
            C_SHIFT: begin
              alu_src_imm = 2'b10;
              state_d     = S_WB;
            end
            C_LOAD, C_STORE: begin
              alu_src_imm = 2'b01;
              state_d     = S_MEM;
            end
            C_BEQZ: begin
              pc_load = alu_zero;
              state_d = S_FETCH;
            end
            C_JUMP: begin
              pc_load  = 1'b1;
              pc_src_l = 1'b1;
              state_d  = S_FETCH;
            end
            default: state_d = is_halt ? S_HALT : S_FETCH;
          endcase
        end
        S_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (op_class == C_STORE);
          if (mem.mem_ready) begin
            state_d = (op_class == C_LOAD) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            state_d = S_ERROR;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          wb_sel_mem = (op_class == C_LOAD);
          state_d    = S_FETCH;
        end
        S_HALT:  halted = 1'b1;
        S_ERROR: err = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Directed plus randomized check of the control FSM against a phase-list model built from the instruction class.
module tb_risc_control_fsm;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] operation;
  logic       alu_zero;
  logic       ir_load, dec_en, alu_en, pc_inc, pc_load, pc_src_l;
  logic       reg_write, wb_sel_mem, halted, err;
  logic [1:0] alu_src_imm;
  logic [2:0] state_dbg;

  risc_control_fsm_if mif();

  risc_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .WAIT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mif),
    .operation   (operation),
    .alu_zero    (alu_zero),
    .ir_load     (ir_load),
    .dec_en      (dec_en),
    .alu_en      (alu_en),
    .alu_src_imm (alu_src_imm),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_src_l    (pc_src_l),
    .reg_write   (reg_write),
    .wb_sel_mem  (wb_sel_mem),
    .halted      (halted),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       dec_en;
    logic       alu_en;
    logic [1:0] alu_src_imm;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_src_l;
    logic       reg_write;
    logic       wb_sel_mem;
    logic       halted;
    logic       err;
    logic [2:0] state;
  } outv_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic outv_t base(input logic [2:0] st);
    outv_t v;
    v       = '0;
    v.state = st;
    return v;
  endfunction

  task automatic check(input string tag, input outv_t exp);
    outv_t obs;
    obs.mem_req      = mif.mem_req;
    obs.mem_we       = mif.mem_we;
    obs.mem_addr_sel = mif.mem_addr_sel;
    obs.ir_load      = ir_load;
    obs.dec_en       = dec_en;
    obs.alu_en       = alu_en;
    obs.alu_src_imm  = alu_src_imm;
    obs.pc_inc       = pc_inc;
    obs.pc_load      = pc_load;
    obs.pc_src_l     = pc_src_l;
    obs.reg_write    = reg_write;
    obs.wb_sel_mem   = wb_sel_mem;
    obs.halted       = halted;
    obs.err          = err;
    obs.state        = state_dbg;
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, sample mid-cycle, advance to the next edge.
  task automatic step(input string tag, input logic [6:0] op, input logic az, input logic mr,
                      input outv_t exp);
    operation     = op;
    alu_zero      = az;
    mif.mem_ready = mr;
    #2;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    mif.mem_ready = 1'b1;
    #1;
    check("rst_async", '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", '0);
    rst_n = 1'b1;
    #1;
  endtask

  // Expected cycle trace of one instruction, derived from its class. A wait count of
  // MEM_TIMEOUT-1 or more stops after the last tolerated miss (the caller checks ERROR);
  // abort_mem asserts reset during the first MEM cycle.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic az,
                           input bit abort_mem);
    logic [2:0] cls;
    outv_t      e;
    cls = op[6:4];
    for (int i = 0; i < fw && i < MEM_TIMEOUT - 1; i++) begin
      e = base(3'd0);
      e.mem_req = 1'b1;
      step("fetch_wait", r7(), r1(), 1'b0, e);
    end
    if (fw >= MEM_TIMEOUT - 1) return;
    e = base(3'd0);
    e.mem_req = 1'b1;
    e.ir_load = 1'b1;
    e.pc_inc  = 1'b1;
    step("fetch", r7(), r1(), 1'b1, e);
    e = base(3'd1);
    e.dec_en = 1'b1;
    step("decode", r7(), r1(), r1(), e);
    e = base(3'd2);
    e.alu_en = 1'b1;
    case (cls)
      3'd1, 3'd3, 3'd4: e.alu_src_imm = 2'b01;
      3'd2:             e.alu_src_imm = 2'b10;
      3'd5:             e.pc_load = az;
      3'd6: begin
        e.pc_load  = 1'b1;
        e.pc_src_l = 1'b1;
      end
      default: ;
    endcase
    step("exec", op, az, r1(), e);
    if (cls == 3'd3 || cls == 3'd4) begin
      e = base(3'd3);
      e.mem_req      = 1'b1;
      e.mem_addr_sel = 1'b1;
      e.mem_we       = (cls == 3'd4);
      if (abort_mem) begin
        operation     = op;
        mif.mem_ready = 1'b0;
        #2;
        check("mem_pre_rst", e);
        rst_n = 1'b0;
        #1;
        check("mem_rst_async", '0);
        return;
      end
      for (int i = 0; i < mw && i < MEM_TIMEOUT - 1; i++) step("mem_wait", op, r1(), 1'b0, e);
      if (mw >= MEM_TIMEOUT - 1) return;
      step("mem", op, r1(), 1'b1, e);
    end
    if (cls <= 3'd3) begin
      e = base(3'd4);
      e.reg_write  = 1'b1;
      e.wb_sel_mem = (cls == 3'd3);
      step("wb", op, r1(), r1(), e);
    end
  endtask

  task automatic expect_error(input int n);
    outv_t e;
    e     = base(3'd6);
    e.err = 1'b1;
    for (int i = 0; i < n; i++) step("error_hold", r7(), r1(), r1(), e);
  endtask

  initial begin
    outv_t e;
    logic [6:0] op;
    rst_n         = 1'b1;
    operation     = '0;
    alu_zero      = 1'b0;
    mif.mem_ready = 1'b1;
    #3;
    do_reset();

    run_instr(7'b0000000, 0, 0, 1'b0, 1'b0);
    run_instr(7'b0110000, 0, 3, 1'b0, 1'b0);
    run_instr(7'b1010000, 0, 0, 1'b1, 1'b0);
    run_instr(7'b1010000, 0, 0, 1'b0, 1'b0);
    run_instr(7'b1100000, 0, 0, 1'b0, 1'b0);
    run_instr(7'b0010101, 1, 0, 1'b0, 1'b0);
    run_instr(7'b0100011, 0, 0, 1'b1, 1'b0);
    run_instr(7'b1000000, 2, 2, 1'b0, 1'b0);
    run_instr(7'b1110000, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = r7();
      if (op[6:4] == 3'd7 && op[3:0] == 4'hF) op[3:0] = 4'h0;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), r1(), 1'b0);
    end

    // HALT holds through arbitrary inputs until reset.
    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0);
    e        = base(3'd5);
    e.halted = 1'b1;
    for (int i = 0; i < 20; i++) step("halt_hold", r7(), r1(), r1(), e);
    do_reset();
    run_instr(7'b0000000, 0, 0, 1'b0, 1'b0);

    // Fetch timeout, then the same wait with ready arriving on the threshold cycle.
    run_instr(7'b0000000, MEM_TIMEOUT - 1, 0, 1'b0, 1'b0);
    expect_error(5);
    do_reset();
    run_instr(7'b0000000, MEM_TIMEOUT - 2, 0, 1'b0, 1'b0);

    // Same pair of boundaries in MEM.
    run_instr(7'b0110000, 0, MEM_TIMEOUT - 2, 1'b0, 1'b0);
    run_instr(7'b0110000, 0, MEM_TIMEOUT - 1, 1'b0, 1'b0);
    expect_error(3);
    do_reset();

    // Reset mid-MEM of a STORE: abandoned, no write strobe after release.
    run_instr(7'b1000000, 0, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_hold", '0);
    rst_n = 1'b1;
    #1;
    run_instr(7'b1000000, 1, 1, 1'b0, 1'b0);
    run_instr(7'b0000000, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
